// File: rtl/core_if_ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_if_ifu_pkg
//  Purpose  : Shared constants and types for the instruction fetch unit:
//             PC width, static-prediction opcodes and fetch FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package core_if_ifu_pkg;

   localparam int CORE_PC_WIDTH = 32;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // IDLE : no request outstanding
   // WAIT : request accepted, response will be registered
   // DROP : request accepted, response will be discarded (flushed)
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/core_if_ifu_bpu.sv
`default_nettype none
// ============================================================================
//  Module   : core_if_bpu
//  Purpose  : Combinational static branch predictor. JAL and backward
//             conditional branches are predicted taken; everything else
//             (including JALR) falls through to pc + 4.
//  Ports    : pc      - PC of the fetched word
//             inst    - fetched instruction word
//             taken   - 1 when fetch continues at the predicted target
//             next_pc - PC of the next fetch
//  Revision : 1.0 - initial release
// ============================================================================
module core_if_bpu
   import core_if_ifu_pkg::*;
(
   input  logic [CORE_PC_WIDTH-1:0] pc,
   input  logic [31:0]              inst,
   output logic                     taken,
   output logic [CORE_PC_WIDTH-1:0] next_pc
);

   logic [CORE_PC_WIDTH-1:0] j_imm;
   logic [CORE_PC_WIDTH-1:0] b_imm;

   assign j_imm = {{(CORE_PC_WIDTH-21){inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};
   assign b_imm = {{(CORE_PC_WIDTH-13){inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};

   // Additions wrap silently at the PC width.
   always_comb begin
      taken   = 1'b0;
      next_pc = pc + CORE_PC_WIDTH'(4);
      if (inst[6:0] == OPC_JAL) begin
         taken   = 1'b1;
         next_pc = pc + j_imm;
      end else if ((inst[6:0] == OPC_BRANCH) && inst[31]) begin
         taken   = 1'b1;
         next_pc = pc + b_imm;
      end
   end

endmodule
`default_nettype wire

// File: rtl/core_if_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : core_if_ifu
//  Purpose  : Instruction fetch stage. Holds the fetch PC, issues one word
//             read at a time on a valid/ready bus, registers the returned
//             word with its PC and static prediction, and hands it to decode.
//             Commit redirects override the PC and squash in-flight fetches.
//  Ports    : clk, rst_n                      - clock, async active-low reset
//             ifu_req_valid/ready/addr        - fetch request channel
//             ifu_rsp_valid/data              - fetch response channel
//             cmt_pipeline_flush_req/flush_pc - redirect from commit
//             valid_out/ready_out             - decode handshake
//             o_pc, o_inst, o_branch_predict  - registered fetch result
//  Revision : 1.0 - initial release
// ============================================================================
module core_if_ifu
   import core_if_ifu_pkg::*;
#(
   parameter logic [CORE_PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     ifu_req_valid,
   input  logic                     ifu_req_ready,
   output logic [CORE_PC_WIDTH-1:0] ifu_req_addr,
   input  logic                     ifu_rsp_valid,
   input  logic [31:0]              ifu_rsp_data,
   input  logic                     cmt_pipeline_flush_req,
   input  logic [CORE_PC_WIDTH-1:0] cmt_flush_pc,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic [CORE_PC_WIDTH-1:0] o_pc,
   output logic [31:0]              o_inst,
   output logic                     o_branch_predict
);

   fetch_state_e             state;
   fetch_state_e             state_nxt;
   logic [CORE_PC_WIDTH-1:0] pc;
   logic                     out_free;
   logic                     load;
   logic                     bpu_taken;
   logic [CORE_PC_WIDTH-1:0] bpu_next_pc;
   logic                     unused_flush_lsb;

   // Low PC bits of a redirect target are ignored by design.
   assign unused_flush_lsb = ^cmt_flush_pc[1:0];

   core_if_bpu u_bpu (
      .pc      (pc),
      .inst    (ifu_rsp_data),
      .taken   (bpu_taken),
      .next_pc (bpu_next_pc)
   );

   // Requests only go out when the output register will be empty, which
   // guarantees a response never meets a stalled output register.
   assign out_free      = ~valid_out | ready_out;
   assign ifu_req_valid = (state == ST_IDLE) & out_free & ~cmt_pipeline_flush_req;
   assign ifu_req_addr  = {pc[CORE_PC_WIDTH-1:2], 2'b00};
   assign load          = (state == ST_WAIT) & ifu_rsp_valid & ~cmt_pipeline_flush_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ifu_req_valid && ifu_req_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ifu_rsp_valid) begin
               state_nxt = ST_IDLE;
            end else if (cmt_pipeline_flush_req) begin
               state_nxt = ST_DROP;
            end
         end
         ST_DROP: begin
            // A flush in DROP keeps waiting for the stale response.
            if (ifu_rsp_valid) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (cmt_pipeline_flush_req) begin
         pc <= {cmt_flush_pc[CORE_PC_WIDTH-1:2], 2'b00};
      end else if (load) begin
         pc <= bpu_next_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
      end else if (cmt_pipeline_flush_req) begin
         valid_out <= 1'b0;
      end else if (load) begin
         valid_out <= 1'b1;
      end else if (ready_out) begin
         valid_out <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_pc             <= '0;
         o_inst           <= '0;
         o_branch_predict <= 1'b0;
      end else if (load) begin
         o_pc             <= pc;
         o_inst           <= ifu_rsp_data;
         o_branch_predict <= bpu_taken;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_if_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_if_ifu
//  Purpose  : Directed self-checking bench for core_if_ifu.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_if_ifu;

   logic        clk;
   logic        rst_n;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rsp_data;
   logic        cmt_pipeline_flush_req;
   logic [31:0] cmt_flush_pc;
   logic        valid_out;
   logic        ready_out;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_branch_predict;

   int checks;
   int errors;

   core_if_ifu dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .ifu_req_valid          (ifu_req_valid),
      .ifu_req_ready          (ifu_req_ready),
      .ifu_req_addr           (ifu_req_addr),
      .ifu_rsp_valid          (ifu_rsp_valid),
      .ifu_rsp_data           (ifu_rsp_data),
      .cmt_pipeline_flush_req (cmt_pipeline_flush_req),
      .cmt_flush_pc           (cmt_flush_pc),
      .valid_out              (valid_out),
      .ready_out              (ready_out),
      .o_pc                   (o_pc),
      .o_inst                 (o_inst),
      .o_branch_predict       (o_branch_predict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete fetch with a 1-cycle response, output accepted by decode.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic bp);
      chk("req_valid", {31'd0, ifu_req_valid}, 32'd1);
      chk("req_addr", ifu_req_addr, addr);
      step();
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data  = data;
      #1;
      chk("wait_req_valid", {31'd0, ifu_req_valid}, 32'd0);
      chk("wait_valid_out", {31'd0, valid_out}, 32'd0);
      step();
      ifu_rsp_valid = 1'b0;
      ifu_rsp_data  = 32'h0;
      #1;
      chk("valid_out", {31'd0, valid_out}, 32'd1);
      chk("o_pc", o_pc, addr);
      chk("o_inst", o_inst, data);
      chk("o_bp", {31'd0, o_branch_predict}, {31'd0, bp});
   endtask

   task automatic flush_to(input logic [31:0] target);
      cmt_pipeline_flush_req = 1'b1;
      cmt_flush_pc           = target;
      #1;
      chk("flush_no_req", {31'd0, ifu_req_valid}, 32'd0);
      step();
      cmt_pipeline_flush_req = 1'b0;
      cmt_flush_pc           = 32'h0;
      #1;
      chk("flush_valid_out", {31'd0, valid_out}, 32'd0);
   endtask

   initial begin
      checks                 = 0;
      errors                 = 0;
      rst_n                  = 1'b0;
      ifu_req_ready          = 1'b1;
      ifu_rsp_valid          = 1'b0;
      ifu_rsp_data           = 32'h0;
      cmt_pipeline_flush_req = 1'b0;
      cmt_flush_pc           = 32'h0;
      ready_out              = 1'b1;

      step();
      step();
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_o_pc", o_pc, 32'h0);
      chk("rst_o_inst", o_inst, 32'h0);
      chk("rst_o_bp", {31'd0, o_branch_predict}, 32'd0);
      rst_n = 1'b1;
      #1;

      // Sequential NOPs
      fetch(32'h8000_0000, 32'h0000_0013, 1'b0);
      fetch(32'h8000_0004, 32'h0000_0013, 1'b0);

      // JAL +16 at 8000_0000
      flush_to(32'h8000_0000);
      fetch(32'h8000_0000, 32'h0100_006F, 1'b1);
      fetch(32'h8000_0010, 32'h0000_0013, 1'b0);

      // Backward branch taken, forward branch not taken
      flush_to(32'h8000_0008);
      fetch(32'h8000_0008, 32'hFE00_0EE3, 1'b1);
      fetch(32'h8000_0004, 32'h0000_0013, 1'b0);
      fetch(32'h8000_0008, 32'h7E00_0EE3, 1'b0);

      // Decode stall for 5 cycles
      ready_out = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'd0, valid_out}, 32'd1);
         chk("stall_o_pc", o_pc, 32'h8000_0008);
         chk("stall_o_inst", o_inst, 32'h7E00_0EE3);
         chk("stall_no_req", {31'd0, ifu_req_valid}, 32'd0);
         step();
      end
      ready_out = 1'b1;
      #1;
      fetch(32'h8000_000C, 32'h0000_0013, 1'b0);

      // Flush while WAIT; stale response 3 cycles later is dropped
      chk("pre_drop_req", {31'd0, ifu_req_valid}, 32'd1);
      chk("pre_drop_addr", ifu_req_addr, 32'h8000_0010);
      step();
      cmt_pipeline_flush_req = 1'b1;
      cmt_flush_pc           = 32'h8000_0103;
      step();
      cmt_pipeline_flush_req = 1'b0;
      cmt_flush_pc           = 32'h0;
      #1;
      chk("drop_valid_out", {31'd0, valid_out}, 32'd0);
      chk("drop_no_req", {31'd0, ifu_req_valid}, 32'd0);
      step();
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data  = 32'h0100_006F;
      #1;
      chk("drop_rsp_no_req", {31'd0, ifu_req_valid}, 32'd0);
      step();
      ifu_rsp_valid = 1'b0;
      ifu_rsp_data  = 32'h0;
      #1;
      chk("after_drop_valid", {31'd0, valid_out}, 32'd0);
      chk("after_drop_o_pc", o_pc, 32'h8000_000C);
      fetch(32'h8000_0100, 32'h0000_0013, 1'b0);

      // Flush coinciding with the response: no DROP, next request to target
      step();
      ifu_rsp_valid          = 1'b1;
      ifu_rsp_data           = 32'h0000_0013;
      cmt_pipeline_flush_req = 1'b1;
      cmt_flush_pc           = 32'h8000_0200;
      step();
      ifu_rsp_valid          = 1'b0;
      cmt_pipeline_flush_req = 1'b0;
      cmt_flush_pc           = 32'h0;
      #1;
      chk("same_cyc_valid", {31'd0, valid_out}, 32'd0);
      fetch(32'h8000_0200, 32'h0000_0013, 1'b0);

      // PC wrap-around, then JALR falls through
      flush_to(32'hFFFF_FFFE);
      fetch(32'hFFFF_FFFC, 32'h0000_0013, 1'b0);
      fetch(32'h0000_0000, 32'h0000_8067, 1'b0);

      // Reset mid-transaction; late response ignored
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
      chk("mid_rst_o_pc", o_pc, 32'h0);
      step();
      rst_n         = 1'b1;
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data  = 32'h0000_0013;
      step();
      ifu_rsp_valid = 1'b0;
      ifu_req_ready = 1'b1;
      #1;
      chk("late_rsp_valid", {31'd0, valid_out}, 32'd0);
      fetch(32'h8000_0000, 32'h0000_0013, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
